// File: rtl/i2c_slave.sv
// I2C target with a fixed 7-bit address, running entirely on the system clock.
// SCL/SDA are oversampled; START/STOP override every state; ACKs and read data drive SDA open-drain.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] data_recv,
  output logic       recv_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
  } state_t;

  // [0],[1] form the synchronizer, [2] is the delayed copy used for edge detection
  logic [2:0] scl_sync_q, scl_sync_d;
  logic [2:0] sda_sync_q, sda_sync_d;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       acked_q, acked_d;
  logic       busy_q, busy_d;
  logic [7:0] data_recv_q, data_recv_d;
  logic       recv_valid_q, recv_valid_d;
  logic       tx_req_q, tx_req_d;

  logic scl_s, scl_p, sda_s, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_sync_d = {scl_sync_q[1:0], scl};
  assign sda_sync_d = {sda_sync_q[1:0], sda};

  assign scl_s     = scl_sync_q[1];
  assign scl_p     = scl_sync_q[2];
  assign sda_s     = sda_sync_q[1];
  assign sda_p     = sda_sync_q[2];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & sda_p & ~sda_s;
  assign stop_det  = scl_s & ~sda_p & sda_s;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rw_d         = rw_q;
    sda_oe_d     = sda_oe_q;
    acked_d      = acked_q;
    busy_d       = busy_q;
    data_recv_d  = data_recv_q;
    recv_valid_d = 1'b0;
    tx_req_d     = 1'b0;

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      acked_d   = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
      acked_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;

        ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (shift_q[6:0] == SLAVE_ADDR) begin
                rw_d    = sda_s;
                state_d = ADDR_ACK;
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end
        end

        // First fall starts the ACK clock, second fall ends it
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              bit_cnt_d = 4'd0;
              if (rw_q) begin
                shift_d  = tx_data;
                tx_req_d = 1'b1;
                sda_oe_d = ~tx_data[7];
                state_d  = READ;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = WRITE;
              end
            end
          end
        end

        WRITE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              data_recv_d  = {shift_q[6:0], sda_s};
              recv_valid_d = 1'b1;
              state_d      = WRITE_ACK;
            end
          end
        end

        WRITE_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = WRITE;
            end
          end
        end

        // Bit 7 is already on the bus; each fall presents the next bit, the 8th releases
        READ: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              sda_oe_d = 1'b0;
              state_d  = READ_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end

        READ_ACK: begin
          if (scl_rise && !acked_q) begin
            if (sda_s) begin
              busy_d  = 1'b0;
              state_d = WAIT_STOP;
            end else begin
              acked_d = 1'b1;
            end
          end else if (scl_fall && acked_q) begin
            acked_d   = 1'b0;
            bit_cnt_d = 4'd0;
            shift_d   = tx_data;
            tx_req_d  = 1'b1;
            sda_oe_d  = ~tx_data[7];
            state_d   = READ;
          end
        end

        WAIT_STOP: sda_oe_d = 1'b0;

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // Bus idles high, so the synchronizers reset to 1 to avoid a false edge
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      scl_sync_q   <= 3'b111;
      sda_sync_q   <= 3'b111;
      state_q      <= IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'd0;
      rw_q         <= 1'b0;
      sda_oe_q     <= 1'b0;
      acked_q      <= 1'b0;
      busy_q       <= 1'b0;
      data_recv_q  <= 8'd0;
      recv_valid_q <= 1'b0;
      tx_req_q     <= 1'b0;
    end else begin
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rw_q         <= rw_d;
      sda_oe_q     <= sda_oe_d;
      acked_q      <= acked_d;
      busy_q       <= busy_d;
      data_recv_q  <= data_recv_d;
      recv_valid_q <= recv_valid_d;
      tx_req_q     <= tx_req_d;
    end
  end

  assign sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign tx_req     = tx_req_q;
  assign data_recv  = data_recv_q;
  assign recv_valid = recv_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a timed I2C controller model (50 MHz clk, 500 kHz SCL)
// exercises write, address mismatch, read, multi-byte write, repeated START and mid-transfer reset.
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam int Q = 500;  // quarter SCL period in ns

  logic       clk;
  logic       arstn;
  logic       scl;
  logic       sda_low;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [7:0] data_recv;
  logic       recv_valid;
  logic       busy;
  wire        sda;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk       (clk),
    .arstn     (arstn),
    .scl       (scl),
    .sda       (sda),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .data_recv (data_recv),
    .recv_valid(recv_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int rv_cnt = 0;
  int tr_cnt = 0;
  int both_cnt = 0;
  int tgt_low_cnt = 0;
  int busy_low_cnt = 0;
  logic [7:0] rv_q[$];

  always @(negedge clk) begin
    if (recv_valid === 1'b1) begin
      rv_cnt++;
      rv_q.push_back(data_recv);
    end
    if (tx_req === 1'b1) tr_cnt++;
    if (recv_valid === 1'b1 && tx_req === 1'b1) both_cnt++;
    if (sda === 1'b0 && !sda_low) tgt_low_cnt++;
    if (busy !== 1'b1) busy_low_cnt++;
  end

  task automatic i2c_start();
    sda_low = 1'b0; #(Q);
    scl = 1'b1; #(Q);
    sda_low = 1'b1; #(Q);
    scl = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; #(Q);
    scl = 1'b1; #(Q);
    sda_low = 1'b0; #(2*Q);
  endtask

  task automatic send_bit(input logic b);
    sda_low = ~b; #(Q);
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_low = 1'b0; #(Q);
    scl = 1'b1; #(Q);
    ack = sda;
    #(Q);
    scl = 1'b0; #(Q);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #(Q); scl = 1'b1;
      #(Q); d[i] = (sda === 1'b1);
      #(Q); scl = 1'b0;
      #(Q);
    end
    sda_low = ~nack; #(Q);
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #(Q);
    sda_low = 1'b0;
  endtask

  task automatic test_reset();
    arstn = 1'b0; scl = 1'b1; sda_low = 1'b0; tx_data = 8'h00;
    repeat (5) @(negedge clk);
    total_cnt++; if (data_recv !== 8'h00) $display("FAIL reset_data_recv: got %h expected 00", data_recv); else pass_cnt++;
    total_cnt++; if (recv_valid !== 1'b0) $display("FAIL reset_recv_valid: got %b expected 0", recv_valid); else pass_cnt++;
    total_cnt++; if (tx_req !== 1'b0) $display("FAIL reset_tx_req: got %b expected 0", tx_req); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (sda !== 1'b1) $display("FAIL reset_sda: got %b expected 1 (released)", sda); else pass_cnt++;
    arstn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_write();
    logic a0, a1;
    int rv0, tl0;
    rv0 = rv_cnt; tl0 = tgt_low_cnt;
    i2c_start();
    send_byte(8'hA0, a0);
    total_cnt++; if (a0 !== 1'b0) $display("FAIL write_addr_ack: got %b expected 0", a0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL write_busy_high: got %b expected 1", busy); else pass_cnt++;
    send_byte(8'h5A, a1);
    total_cnt++; if (a1 !== 1'b0) $display("FAIL write_data_ack: got %b expected 0", a1); else pass_cnt++;
    total_cnt++; if (data_recv !== 8'h5A) $display("FAIL write_data: got %h expected 5a", data_recv); else pass_cnt++;
    total_cnt++; if (rv_cnt - rv0 !== 1) $display("FAIL write_rv_pulses: got %0d expected 1", rv_cnt - rv0); else pass_cnt++;
    total_cnt++; if (tgt_low_cnt == tl0) $display("FAIL write_target_drove: got %0d cycles expected nonzero", tgt_low_cnt - tl0); else pass_cnt++;
    i2c_stop();
    total_cnt++; if (busy !== 1'b0) $display("FAIL write_busy_after_stop: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_mismatch();
    logic a0;
    int rv0, tr0, tl0;
    rv0 = rv_cnt; tr0 = tr_cnt; tl0 = tgt_low_cnt;
    i2c_start();
    send_byte(8'hA2, a0);
    total_cnt++; if (a0 !== 1'b1) $display("FAIL mismatch_nack: got %b expected 1", a0); else pass_cnt++;
    total_cnt++; if (tgt_low_cnt - tl0 !== 0) $display("FAIL mismatch_sda_driven: got %0d cycles expected 0", tgt_low_cnt - tl0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mismatch_busy: got %b expected 0", busy); else pass_cnt++;
    i2c_stop();
    total_cnt++; if (rv_cnt - rv0 !== 0 || tr_cnt - tr0 !== 0)
      $display("FAIL mismatch_pulses: got rv=%0d tr=%0d expected 0/0", rv_cnt - rv0, tr_cnt - tr0); else pass_cnt++;
  endtask

  task automatic test_read();
    logic a0;
    logic [7:0] d;
    int tr0;
    tr0 = tr_cnt; tx_data = 8'hC3;
    i2c_start();
    send_byte(8'hA1, a0);
    total_cnt++; if (a0 !== 1'b0) $display("FAIL read_addr_ack: got %b expected 0", a0); else pass_cnt++;
    recv_byte(1'b1, d);
    total_cnt++; if (d !== 8'hC3) $display("FAIL read_data: got %h expected c3", d); else pass_cnt++;
    total_cnt++; if (tr_cnt - tr0 !== 1) $display("FAIL read_tx_req: got %0d expected 1", tr_cnt - tr0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL read_busy_after_nack: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (sda !== 1'b1) $display("FAIL read_sda_released: got %b expected 1", sda); else pass_cnt++;
    i2c_stop();
  endtask

  task automatic test_multi_write();
    logic a0, a1, a2, a3;
    int rv0, base;
    rv0 = rv_cnt; base = rv_q.size();
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h11, a1);
    send_byte(8'h22, a2);
    send_byte(8'h33, a3);
    i2c_stop();
    total_cnt++; if ({a0, a1, a2, a3} !== 4'b0000) $display("FAIL multi_acks: got %b expected 0000", {a0, a1, a2, a3}); else pass_cnt++;
    total_cnt++; if (rv_cnt - rv0 !== 3) $display("FAIL multi_rv_pulses: got %0d expected 3", rv_cnt - rv0); else pass_cnt++;
    total_cnt++; if (rv_q.size() < base + 3 || rv_q[base] !== 8'h11 || rv_q[base+1] !== 8'h22 || rv_q[base+2] !== 8'h33)
      $display("FAIL multi_order: got %0d bytes, last %h expected 11 22 33", rv_q.size() - base, data_recv); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2;
    logic [7:0] d;
    int rv0, tr0, bl0;
    rv0 = rv_cnt; tr0 = tr_cnt; tx_data = 8'h3C;
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'hA5, a1);
    bl0 = busy_low_cnt;
    i2c_start();
    send_byte(8'hA1, a2);
    total_cnt++; if (busy_low_cnt - bl0 !== 0) $display("FAIL rs_busy_dropped: got %0d low cycles expected 0", busy_low_cnt - bl0); else pass_cnt++;
    total_cnt++; if ({a0, a1, a2} !== 3'b000) $display("FAIL rs_acks: got %b expected 000", {a0, a1, a2}); else pass_cnt++;
    recv_byte(1'b1, d);
    i2c_stop();
    total_cnt++; if (rv_cnt - rv0 !== 1 || data_recv !== 8'hA5)
      $display("FAIL rs_write: got %0d pulses data %h expected 1 pulse a5", rv_cnt - rv0, data_recv); else pass_cnt++;
    total_cnt++; if (d !== 8'h3C) $display("FAIL rs_read_data: got %h expected 3c", d); else pass_cnt++;
    total_cnt++; if (tr_cnt - tr0 !== 1) $display("FAIL rs_tx_req: got %0d expected 1", tr_cnt - tr0); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic a0, a1;
    int rv0;
    i2c_start();
    send_byte(8'hA0, a0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    sda_low = 1'b0; #(Q);
    scl = 1'b1; #(Q);
    total_cnt++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b expected 1", busy); else pass_cnt++;
    arstn = 1'b0;
    #1;
    total_cnt++; if (sda !== 1'b1) $display("FAIL rstmid_sda: got %b expected 1", sda); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || data_recv !== 8'h00 || recv_valid !== 1'b0 || tx_req !== 1'b0)
      $display("FAIL rstmid_outputs: got busy=%b data=%h rv=%b tr=%b expected 0 00 0 0", busy, data_recv, recv_valid, tx_req); else pass_cnt++;
    #(Q);
    scl = 1'b0; #(Q);
    arstn = 1'b1; #(Q);
    i2c_stop();
    rv0 = rv_cnt;
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h77, a1);
    i2c_stop();
    total_cnt++; if ({a0, a1} !== 2'b00) $display("FAIL rstmid_acks: got %b expected 00", {a0, a1}); else pass_cnt++;
    total_cnt++; if (rv_cnt - rv0 !== 1 || data_recv !== 8'h77)
      $display("FAIL rstmid_write: got %0d pulses data %h expected 1 pulse 77", rv_cnt - rv0, data_recv); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy_after: got %b expected 0", busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_multi_write();
    test_back_to_back();
    test_reset_mid();
    total_cnt++; if (both_cnt !== 0) $display("FAIL rv_tr_overlap: got %0d cycles expected 0", both_cnt); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
